memory_turn_ctrl: RTL and testbench
===================================

Name: memory_turn_ctrl

Overview:
- Turn sequencer for the two-player memory (pairs) board.
- Owns the cursor, the first and second pick, the label compare, the per-turn countdown, player alternation and scoring.
- Drives one-hot revealed/matched masks that the tile cells consume as their select and pair indications.
- Sits between the debounced button and tick logic and the tile array.

Parameters:
N_TILES, 16, number of tiles; must be even and at least 4.
LABEL_W, 4, label width per tile.
TURN_TICKS, 15, ticks allowed per turn; at least 1.
SHOW_TICKS, 2, ticks a mismatched pair stays visible; at least 1.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
tick  in  1  one-cycle timebase strobe
btn_next  in  1  one-cycle pulse; advance cursor
btn_select  in  1  one-cycle pulse; pick tile under cursor
labels  in  N_TILES*LABEL_W  tile i label at [i*LABEL_W +: LABEL_W]; static during a game
cursor  out  clog2(N_TILES)  current cursor index
revealed  out  N_TILES  face-up, unmatched tiles
matched  out  N_TILES  tiles already paired
player  out  1  player whose turn it is
score0  out  clog2(N_TILES/2+1)  pairs won by player 0
score1  out  clog2(N_TILES/2+1)  pairs won by player 1
time_left  out  clog2(TURN_TICKS+1)  remaining ticks this turn
time_up  out  1  one-cycle pulse on turn timeout
match_pulse  out  1  one-cycle pulse on a successful pair
game_over  out  1  high once all tiles are matched

Behaviour:
- Reset values (asynchronous, rst=1):
  - state=PICK1, cursor=0, player=0, score0=score1=0.
  - revealed=0, matched=0, time_left=TURN_TICKS.
  - time_up=0, match_pulse=0, game_over=0.
  - Reset mid-turn or mid-SHOW discards everything, including scores.
- Cursor:
  - btn_next moves the cursor +1 modulo N_TILES, with wrap-around N_TILES-1 -> 0.
  - Matched tiles are not skipped.
  - Active in PICK1 and PICK2 only; ignored in SHOW and GAME_OVER.
- Legal pick:
  - In PICK1, the cursor tile must be neither matched nor revealed.
  - In PICK2, the same rule applies, and the tile must differ from the first pick.
  - An illegal select is ignored: no state change, no timer effect.
- PICK1:
  - Legal select: set revealed[cursor], store idx1=cursor, go to PICK2.
  - The timer keeps running and is not reloaded.
- PICK2, legal select:
  - Set revealed[cursor] and compare labels[idx1] with labels[cursor] in the same cycle.
  - Equal:
    - Next cycle, set matched at both indices and clear both from revealed.
    - Increment the current player's score and pulse match_pulse for 1 cycle.
    - The same player keeps the turn; time_left reloads to TURN_TICKS and the FSM goes to PICK1.
    - If matched becomes all-ones, go to GAME_OVER instead.
  - Not equal: go to SHOW and load the show counter with SHOW_TICKS.
- SHOW:
  - All buttons are ignored and the turn timer is frozen.
  - Each tick decrements the show counter.
  - The cycle the counter reaches 0: clear revealed, toggle player, reload time_left, go to PICK1.
- Turn timer:
  - In PICK1 and PICK2, each tick decrements time_left while it is above 0.
  - The tick that moves time_left 1 -> 0 pulses time_up for that cycle and forfeits the turn.
  - Forfeit: clear revealed (any first pick re-hides), toggle player, reload time_left, go to PICK1.
  - Scores and matched are untouched by a forfeit.
- Simultaneous events:
  - A legal select in the same cycle as the expiring tick takes priority: the select is processed and no time_up is generated.
  - If that select is in PICK1, the FSM enters PICK2 with time_left 0. The next tick then forfeits, pulsing time_up when time_left is already 0.
  - btn_next together with btn_select: the select uses the pre-move cursor, and the cursor still advances.
- GAME_OVER:
  - game_over=1; masks and scores frozen; all inputs ignored until rst.
- Scores never overflow, since the maximum is N_TILES/2.
- Outputs are registered, except that cursor, revealed and matched are directly the state registers.

Test Plan:
1. Reset, labels[i]=i>>1, select at cursor 0, 1 next, select -> match_pulse at cycle+1, matched=0x0003, score0=1, player=0, time_left=15.
2. Pairs board, select at 0, 2 next, select at 2 -> SHOW; after 2 ticks revealed=0, player=1, time_left=15; buttons during SHOW have no effect.
3. Select at 0, then 15 ticks with no second pick -> time_up pulse on tick 15, revealed=0, player=1, time_left=15.
4. Select on an already-matched tile, and select the first-pick tile again in PICK2 -> ignored, state and masks unchanged.
5. Select in PICK1 coinciding with the expiring tick -> revealed bit set, no time_up; next tick pulses time_up and forfeits.
6. Play all 8 pairs correctly alternating misses -> game_over=1, matched=0xFFFF, score0+score1=8; later inputs ignored; rst mid-game clears all outputs asynchronously.

Source files
------------

// File: rtl/memory_turn_ctrl_if.sv
// Purpose: bundles the turn controller's button/tick inputs, tile labels and board status outputs.
// Latency: none; this is wiring only.
// Backpressure: none; the buttons and tick are single-cycle strobes with no ready path.
//
// Ports (master = stimulus/button side, slave = turn controller):
//   tick, btn_next, btn_select, labels   master -> slave
//   cursor, revealed, matched, player,
//   score0, score1, time_left, time_up,
//   match_pulse, game_over               slave -> master
interface memory_turn_ctrl_if #(
    parameter int N_TILES    = 16,
    parameter int LABEL_W    = 4,
    parameter int TURN_TICKS = 15
);
    localparam int CUR_W = $clog2(N_TILES);
    localparam int SC_W  = $clog2(N_TILES / 2 + 1);
    localparam int TL_W  = $clog2(TURN_TICKS + 1);

    logic                         tick;
    logic                         btn_next;
    logic                         btn_select;
    logic [N_TILES*LABEL_W-1:0]   labels;
    logic [CUR_W-1:0]             cursor;
    logic [N_TILES-1:0]           revealed;
    logic [N_TILES-1:0]           matched;
    logic                         player;
    logic [SC_W-1:0]              score0;
    logic [SC_W-1:0]              score1;
    logic [TL_W-1:0]              time_left;
    logic                         time_up;
    logic                         match_pulse;
    logic                         game_over;

    modport master (
        output tick, btn_next, btn_select, labels,
        input  cursor, revealed, matched, player, score0, score1,
               time_left, time_up, match_pulse, game_over
    );

    modport slave (
        input  tick, btn_next, btn_select, labels,
        output cursor, revealed, matched, player, score0, score1,
               time_left, time_up, match_pulse, game_over
    );
endinterface

// File: rtl/memory_turn_ctrl.sv
// Purpose: turn sequencer for a two-player pairs game (cursor, picks, compare, timer, scoring).
// Latency: picks reflect in revealed one cycle after select; a match lands one cycle later.
// Backpressure: none; inputs arriving while a state ignores them are dropped.
//
// Ports: clk, rst (async active-high); bus (slave modport) carries tick/btn_next/btn_select/labels
// in, and cursor/revealed/matched/player/scores/time_left/time_up/match_pulse/game_over out.
module memory_turn_ctrl #(
    parameter int N_TILES    = 16,
    parameter int LABEL_W    = 4,
    parameter int TURN_TICKS = 15,
    parameter int SHOW_TICKS = 2
) (
    input  logic              clk,
    input  logic              rst,
    memory_turn_ctrl_if.slave bus
);
    localparam int CUR_W = $clog2(N_TILES);
    localparam int SC_W  = $clog2(N_TILES / 2 + 1);
    localparam int TL_W  = $clog2(TURN_TICKS + 1);
    localparam int SH_W  = $clog2(SHOW_TICKS + 1);

    localparam logic [CUR_W-1:0] CUR_LAST  = CUR_W'(N_TILES - 1);
    localparam logic [TL_W-1:0]  TL_RELOAD = TL_W'(TURN_TICKS);
    localparam logic [SH_W-1:0]  SH_RELOAD = SH_W'(SHOW_TICKS);

    // ST_MATCH is the one-cycle gap between the second pick and committing the pair.
    typedef enum logic [2:0] {
        ST_PICK1,
        ST_PICK2,
        ST_MATCH,
        ST_SHOW,
        ST_OVER
    } state_t;

    state_t               state_q,       state_d;
    logic [CUR_W-1:0]     cursor_q,      cursor_d;
    logic [CUR_W-1:0]     idx1_q,        idx1_d;
    logic [CUR_W-1:0]     idx2_q,        idx2_d;
    logic [N_TILES-1:0]   revealed_q,    revealed_d;
    logic [N_TILES-1:0]   matched_q,     matched_d;
    logic                 player_q,      player_d;
    logic [SC_W-1:0]      score0_q,      score0_d;
    logic [SC_W-1:0]      score1_q,      score1_d;
    logic [TL_W-1:0]      time_left_q,   time_left_d;
    logic [SH_W-1:0]      show_cnt_q,    show_cnt_d;
    logic                 time_up_q,     time_up_d;
    logic                 match_pulse_q, match_pulse_d;
    logic                 game_over_q,   game_over_d;

    logic [LABEL_W-1:0]   label_first;
    logic [LABEL_W-1:0]   label_cursor;
    logic                 sel_legal;
    logic [N_TILES-1:0]   pair_mask;

    assign label_first  = bus.labels[idx1_q * LABEL_W +: LABEL_W];
    assign label_cursor = bus.labels[cursor_q * LABEL_W +: LABEL_W];

    // A pick must land on a face-down, unmatched tile; the second pick also may not reuse the first.
    always_comb begin
        sel_legal = 1'b0;
        if (bus.btn_select && !matched_q[cursor_q] && !revealed_q[cursor_q]) begin
            if (state_q == ST_PICK1) begin
                sel_legal = 1'b1;
            end else if (state_q == ST_PICK2 && cursor_q != idx1_q) begin
                sel_legal = 1'b1;
            end
        end
    end

    always_comb begin
        pair_mask         = '0;
        pair_mask[idx1_q] = 1'b1;
        pair_mask[idx2_q] = 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        idx1_d        = idx1_q;
        idx2_d        = idx2_q;
        revealed_d    = revealed_q;
        matched_d     = matched_q;
        player_d      = player_q;
        score0_d      = score0_q;
        score1_d      = score1_q;
        time_left_d   = time_left_q;
        show_cnt_d    = show_cnt_q;
        time_up_d     = 1'b0;
        match_pulse_d = 1'b0;
        game_over_d   = game_over_q;

        unique case (state_q)
            ST_PICK1, ST_PICK2: begin
                if (bus.btn_next) begin
                    cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + CUR_W'(1);
                end
                if (sel_legal) begin
                    // A legal pick wins over an expiring tick; the timer may reach 0 without
                    // forfeiting, and the following tick then forfeits from 0.
                    revealed_d[cursor_q] = 1'b1;
                    if (bus.tick && time_left_q != '0) begin
                        time_left_d = time_left_q - TL_W'(1);
                    end
                    if (state_q == ST_PICK1) begin
                        idx1_d  = cursor_q;
                        state_d = ST_PICK2;
                    end else if (label_first == label_cursor) begin
                        idx2_d  = cursor_q;
                        state_d = ST_MATCH;
                    end else begin
                        show_cnt_d = SH_RELOAD;
                        state_d    = ST_SHOW;
                    end
                end else if (bus.tick) begin
                    if (time_left_q <= TL_W'(1)) begin
                        time_up_d   = 1'b1;
                        revealed_d  = '0;
                        player_d    = ~player_q;
                        time_left_d = TL_RELOAD;
                        state_d     = ST_PICK1;
                    end else begin
                        time_left_d = time_left_q - TL_W'(1);
                    end
                end
            end

            ST_MATCH: begin
                matched_d     = matched_q | pair_mask;
                revealed_d    = revealed_q & ~pair_mask;
                match_pulse_d = 1'b1;
                time_left_d   = TL_RELOAD;
                if (player_q) begin
                    score1_d = score1_q + SC_W'(1);
                end else begin
                    score0_d = score0_q + SC_W'(1);
                end
                if (&matched_d) begin
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end else begin
                    state_d = ST_PICK1;
                end
            end

            ST_SHOW: begin
                // Turn timer is frozen here; only the show counter consumes ticks.
                if (bus.tick) begin
                    if (show_cnt_q <= SH_W'(1)) begin
                        show_cnt_d  = '0;
                        revealed_d  = '0;
                        player_d    = ~player_q;
                        time_left_d = TL_RELOAD;
                        state_d     = ST_PICK1;
                    end else begin
                        show_cnt_d = show_cnt_q - SH_W'(1);
                    end
                end
            end

            ST_OVER: begin
                // Everything holds until reset.
            end

            default: begin
                state_d = ST_PICK1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_PICK1;
            cursor_q      <= '0;
            idx1_q        <= '0;
            idx2_q        <= '0;
            revealed_q    <= '0;
            matched_q     <= '0;
            player_q      <= 1'b0;
            score0_q      <= '0;
            score1_q      <= '0;
            time_left_q   <= TL_RELOAD;
            show_cnt_q    <= '0;
            time_up_q     <= 1'b0;
            match_pulse_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            idx1_q        <= idx1_d;
            idx2_q        <= idx2_d;
            revealed_q    <= revealed_d;
            matched_q     <= matched_d;
            player_q      <= player_d;
            score0_q      <= score0_d;
            score1_q      <= score1_d;
            time_left_q   <= time_left_d;
            show_cnt_q    <= show_cnt_d;
            time_up_q     <= time_up_d;
            match_pulse_q <= match_pulse_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.cursor      = cursor_q;
    assign bus.revealed    = revealed_q;
    assign bus.matched     = matched_q;
    assign bus.player      = player_q;
    assign bus.score0      = score0_q;
    assign bus.score1      = score1_q;
    assign bus.time_left   = time_left_q;
    assign bus.time_up     = time_up_q;
    assign bus.match_pulse = match_pulse_q;
    assign bus.game_over   = game_over_q;
endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Bench for memory_turn_ctrl: fixed vector table, hand-written corner sequences, and randomized play
// compared cycle by cycle against a rule-level game model.
module tb_memory_turn_ctrl;
    localparam int N  = 16;
    localparam int LW = 4;
    localparam int TT = 15;
    localparam int ST = 2;

    localparam int PH_PICK1 = 0;
    localparam int PH_PICK2 = 1;
    localparam int PH_PEND  = 2;
    localparam int PH_SHOW  = 3;
    localparam int PH_OVER  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_turn_ctrl_if #(.N_TILES(N), .LABEL_W(LW), .TURN_TICKS(TT)) intf ();

    memory_turn_ctrl #(
        .N_TILES(N), .LABEL_W(LW), .TURN_TICKS(TT), .SHOW_TICKS(ST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    int checks   = 0;
    int failures = 0;

    // Game model: plain integers describing the board as the rules define it.
    int         m_phase, m_cursor, m_first, m_second, m_player, m_s0, m_s1, m_tl, m_show;
    bit         m_tup, m_mp, m_go;
    bit [N-1:0] m_rev, m_mat;
    int         lab [N];

    typedef struct packed {
        bit          t;
        bit          n;
        bit          s;
        logic [3:0]  cur;
        logic [15:0] rev;
        logic [15:0] mat;
        bit          ply;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic [3:0]  tl;
        bit          tup;
        bit          mp;
        bit          go;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_PICK1; m_cursor = 0; m_first = 0; m_second = 0;
        m_player = 0; m_s0 = 0; m_s1 = 0; m_tl = TT; m_show = 0;
        m_tup = 0; m_mp = 0; m_go = 0; m_rev = '0; m_mat = '0;
    endtask

    task automatic end_turn();
        m_rev    = '0;
        m_player = 1 - m_player;
        m_tl     = TT;
        m_phase  = PH_PICK1;
    endtask

    task automatic model_step(input bit t, input bit n, input bit s);
        int  c;
        bit  legal;
        m_tup = 0;
        m_mp  = 0;
        if (m_phase == PH_PICK1 || m_phase == PH_PICK2) begin
            c     = m_cursor;
            legal = s && !m_mat[c] && !m_rev[c] && !(m_phase == PH_PICK2 && c == m_first);
            if (n) m_cursor = (m_cursor + 1) % N;
            if (legal) begin
                m_rev[c] = 1;
                if (t && m_tl > 0) m_tl--;
                if (m_phase == PH_PICK1) begin
                    m_first = c;
                    m_phase = PH_PICK2;
                end else if (lab[m_first] == lab[c]) begin
                    m_second = c;
                    m_phase  = PH_PEND;
                end else begin
                    m_show  = ST;
                    m_phase = PH_SHOW;
                end
            end else if (t) begin
                if (m_tl > 0) m_tl--;
                if (m_tl == 0) begin
                    m_tup = 1;
                    end_turn();
                end
            end
        end else if (m_phase == PH_PEND) begin
            m_mat[m_first]  = 1;
            m_mat[m_second] = 1;
            m_rev[m_first]  = 0;
            m_rev[m_second] = 0;
            if (m_player == 0) m_s0++; else m_s1++;
            m_mp = 1;
            m_tl = TT;
            if (&m_mat) begin
                m_go    = 1;
                m_phase = PH_OVER;
            end else begin
                m_phase = PH_PICK1;
            end
        end else if (m_phase == PH_SHOW) begin
            if (t) begin
                m_show--;
                if (m_show == 0) end_turn();
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".cursor"},      32'(intf.cursor),      32'(m_cursor));
        chk({tag, ".revealed"},    32'(intf.revealed),    32'(m_rev));
        chk({tag, ".matched"},     32'(intf.matched),     32'(m_mat));
        chk({tag, ".player"},      32'(intf.player),      32'(m_player));
        chk({tag, ".score0"},      32'(intf.score0),      32'(m_s0));
        chk({tag, ".score1"},      32'(intf.score1),      32'(m_s1));
        chk({tag, ".time_left"},   32'(intf.time_left),   32'(m_tl));
        chk({tag, ".time_up"},     32'(intf.time_up),     32'(m_tup));
        chk({tag, ".match_pulse"}, 32'(intf.match_pulse), 32'(m_mp));
        chk({tag, ".game_over"},   32'(intf.game_over),   32'(m_go));
    endtask

    task automatic set_labels();
        for (int i = 0; i < N; i++) intf.labels[i*LW +: LW] = LW'(lab[i]);
    endtask

    // Called one step after a rising edge; leaves the bench one step after the next rising edge.
    task automatic cyc(input bit t, input bit n, input bit s, input string tag);
        intf.tick = t; intf.btn_next = n; intf.btn_select = s;
        model_step(t, n, s);
        @(posedge clk);
        #1;
        intf.tick = 0; intf.btn_next = 0; intf.btn_select = 0;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        intf.tick = 0; intf.btn_next = 0; intf.btn_select = 0;
        rst = 1;
        model_reset();
        #2;
        check_model(tag);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic move_to(input int target);
        for (int k = 0; k < N && m_cursor != target; k++) cyc(0, 1, 0, "move");
    endtask

    initial begin
        intf.labels = '0;
        rst = 1;
        for (int i = 0; i < N; i++) lab[i] = i >> 1;
        set_labels();
        do_reset("reset");

        // Vector table: a matched pair, then a mismatch with buttons pressed during the show.
        vecs.push_back('{0,0,1, 4'd0, 16'h0001, 16'h0000, 0, 4'd0, 4'd0, 4'd15, 0, 0, 0});
        vecs.push_back('{0,1,0, 4'd1, 16'h0001, 16'h0000, 0, 4'd0, 4'd0, 4'd15, 0, 0, 0});
        vecs.push_back('{0,0,1, 4'd1, 16'h0003, 16'h0000, 0, 4'd0, 4'd0, 4'd15, 0, 0, 0});
        vecs.push_back('{0,0,0, 4'd1, 16'h0000, 16'h0003, 0, 4'd1, 4'd0, 4'd15, 0, 1, 0});
        vecs.push_back('{0,0,0, 4'd1, 16'h0000, 16'h0003, 0, 4'd1, 4'd0, 4'd15, 0, 0, 0});
        vecs.push_back('{0,1,0, 4'd2, 16'h0000, 16'h0003, 0, 4'd1, 4'd0, 4'd15, 0, 0, 0});
        vecs.push_back('{0,0,1, 4'd2, 16'h0004, 16'h0003, 0, 4'd1, 4'd0, 4'd15, 0, 0, 0});
        vecs.push_back('{0,1,0, 4'd3, 16'h0004, 16'h0003, 0, 4'd1, 4'd0, 4'd15, 0, 0, 0});
        vecs.push_back('{0,1,0, 4'd4, 16'h0004, 16'h0003, 0, 4'd1, 4'd0, 4'd15, 0, 0, 0});
        vecs.push_back('{0,0,1, 4'd4, 16'h0014, 16'h0003, 0, 4'd1, 4'd0, 4'd15, 0, 0, 0});
        vecs.push_back('{0,1,0, 4'd4, 16'h0014, 16'h0003, 0, 4'd1, 4'd0, 4'd15, 0, 0, 0});
        vecs.push_back('{0,0,1, 4'd4, 16'h0014, 16'h0003, 0, 4'd1, 4'd0, 4'd15, 0, 0, 0});
        vecs.push_back('{1,0,0, 4'd4, 16'h0014, 16'h0003, 0, 4'd1, 4'd0, 4'd15, 0, 0, 0});
        vecs.push_back('{1,0,0, 4'd4, 16'h0000, 16'h0003, 1, 4'd1, 4'd0, 4'd15, 0, 0, 0});
        foreach (vecs[k]) begin
            string tg;
            tg = $sformatf("vec%0d", k);
            cyc(vecs[k].t, vecs[k].n, vecs[k].s, tg);
            chk({tg, ".t_cursor"},   32'(intf.cursor),      32'(vecs[k].cur));
            chk({tg, ".t_revealed"}, 32'(intf.revealed),    32'(vecs[k].rev));
            chk({tg, ".t_matched"},  32'(intf.matched),     32'(vecs[k].mat));
            chk({tg, ".t_player"},   32'(intf.player),      32'(vecs[k].ply));
            chk({tg, ".t_score0"},   32'(intf.score0),      32'(vecs[k].s0));
            chk({tg, ".t_score1"},   32'(intf.score1),      32'(vecs[k].s1));
            chk({tg, ".t_time"},     32'(intf.time_left),   32'(vecs[k].tl));
            chk({tg, ".t_time_up"},  32'(intf.time_up),     32'(vecs[k].tup));
            chk({tg, ".t_match"},    32'(intf.match_pulse), 32'(vecs[k].mp));
            chk({tg, ".t_over"},     32'(intf.game_over),   32'(vecs[k].go));
        end

        // Timeout: first pick then 15 ticks with no second pick.
        do_reset("reset_to");
        cyc(0, 0, 1, "to_pick");
        for (int k = 1; k <= TT; k++) begin
            cyc(1, 0, 0, "to_tick");
            if (k == TT - 1) chk("to_no_early_up", 32'(intf.time_up), 32'd0);
        end
        chk("to_time_up", 32'(intf.time_up), 32'd1);
        chk("to_revealed", 32'(intf.revealed), 32'd0);
        chk("to_player", 32'(intf.player), 32'd1);
        chk("to_reload", 32'(intf.time_left), 32'(TT));

        // Illegal picks: a matched tile, and the first-pick tile again.
        do_reset("reset_il");
        cyc(0, 0, 1, "il"); cyc(0, 1, 0, "il"); cyc(0, 0, 1, "il"); cyc(0, 0, 0, "il");
        move_to(0);
        cyc(0, 0, 1, "il_matched");
        chk("il_matched_rev", 32'(intf.revealed), 32'h0);
        move_to(2);
        cyc(0, 0, 1, "il_first");
        cyc(0, 0, 1, "il_again");
        chk("il_again_rev", 32'(intf.revealed), 32'h4);
        chk("il_again_mat", 32'(intf.matched), 32'h3);

        // Pick coinciding with the expiring tick, then forfeit from time_left 0.
        do_reset("reset_co");
        for (int k = 0; k < TT - 1; k++) cyc(1, 0, 0, "co_tick");
        chk("co_tl_one", 32'(intf.time_left), 32'd1);
        cyc(1, 0, 1, "co_both");
        chk("co_rev", 32'(intf.revealed), 32'h1);
        chk("co_no_up", 32'(intf.time_up), 32'd0);
        chk("co_tl_zero", 32'(intf.time_left), 32'd0);
        cyc(1, 0, 0, "co_forfeit");
        chk("co_up", 32'(intf.time_up), 32'd1);
        chk("co_player", 32'(intf.player), 32'd1);

        // Full game with misses on even pairs, then frozen inputs and an async reset.
        do_reset("reset_game");
        for (int p = 0; p < N / 2; p++) begin
            if (p % 2 == 0 && p < N / 2 - 1) begin
                move_to(2 * p); cyc(0, 0, 1, "g_miss1");
                move_to(2 * p + 2); cyc(0, 0, 1, "g_miss2");
                cyc(1, 0, 0, "g_show"); cyc(1, 0, 0, "g_show");
            end
            move_to(2 * p); cyc(0, 0, 1, "g_hit1");
            move_to(2 * p + 1); cyc(0, 0, 1, "g_hit2");
            cyc(0, 0, 0, "g_commit");
        end
        chk("g_over", 32'(intf.game_over), 32'd1);
        chk("g_matched", 32'(intf.matched), 32'hFFFF);
        chk("g_total", 32'(intf.score0) + 32'(intf.score1), 32'd8);
        for (int k = 0; k < 20; k++) cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), "g_frozen");
        chk("g_still_over", 32'(intf.game_over), 32'd1);

        do_reset("reset_async");
        cyc(0, 0, 1, "as"); cyc(0, 1, 0, "as"); cyc(0, 0, 1, "as"); cyc(0, 0, 0, "as");
        #2;
        rst = 1;
        model_reset();
        #1;
        check_model("async");
        @(posedge clk);
        #1;
        rst = 0;

        // Randomized play on shuffled pair boards.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) lab[i] = i / 2;
            for (int i = N - 1; i > 0; i--) begin
                int j, tmp;
                j = $urandom_range(0, i);
                tmp = lab[i]; lab[i] = lab[j]; lab[j] = tmp;
            end
            set_labels();
            do_reset("reset_rnd");
            for (int k = 0; k < 800; k++) begin
                if (m_phase == PH_OVER && $urandom_range(0, 19) == 0) do_reset("reset_rnd_over");
                cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0, "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
